// File: rtl/waveform_trace_buffer.sv
// Purpose : circular sample store for the scrolling ECG trace, replayed one sample per screen column.
// Latency : 2 cycles from hcount/vcount to signal_out/signal_valid/hcount_d/vcount_d, fixed, every cycle.
// Backpr. : sample_ready drops while freeze or clear is high (or in reset); the read side never stalls.
//
// Ports:
//   clock_65mhz, reset_n        pixel clock, asynchronous active-low reset
//   sample_in/valid/ready       8-bit trace sample handshake into the buffer
//   freeze                      hold the trace, writes blocked
//   clear                       one-cycle synchronous empty of the buffer
//   frame_start                 one-cycle pulse at vertical blank; snapshots head and fill
//   hcount, vcount              current raster position
//   signal_out, signal_valid    sample for column hcount_d and its validity
//   hcount_d, vcount_d          raster position delayed to line up with signal_out
//   fill_level                  live count of stored samples, 0..WIDTH
module waveform_trace_buffer #(
    parameter int WIDTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic               clock_65mhz,
    input  logic               reset_n,
    input  logic [7:0]         sample_in,
    input  logic               sample_valid,
    output logic               sample_ready,
    input  logic               freeze,
    input  logic               clear,
    input  logic               frame_start,
    input  logic [10:0]        hcount,
    input  logic [9:0]         vcount,
    output logic [7:0]         signal_out,
    output logic               signal_valid,
    output logic [10:0]        hcount_d,
    output logic [9:0]         vcount_d,
    output logic [ADDR_W:0]    fill_level
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL      = CNT_W'(WIDTH);
    localparam logic [11:0]      WIDTH_EXT = 12'(WIDTH);

    // Stage-1 side information travelling alongside the RAM address.
    typedef struct packed {
        logic [10:0] hcount;
        logic [9:0]  vcount;
        logic        in_range;
        logic        col_ok;
    } rd_stage_t;

    // ------------------------------------------------------------------
    // Write-side state
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0]  r_fill;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_fill_snap;
    logic [7:0]        r_mem [0:WIDTH-1];

    logic              w_accept;

    // Ready is gated by reset_n so it reads 0 while the block is held in reset.
    assign sample_ready = reset_n & ~freeze & ~clear;
    assign w_accept     = sample_valid & sample_ready;
    assign fill_level   = r_fill;

    always_ff @(posedge clock_65mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_base      <= '0;
            r_fill_snap <= '0;
        end else begin
            // w_accept is already false while clear is high, so a write
            // racing a clear is simply dropped.
            if (clear) begin
                r_wr_ptr <= '0;
                r_fill   <= '0;
            end else if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_fill != FULL) begin
                    r_fill <= r_fill + 1'b1;
                end
            end

            // The snapshot samples pre-update values: a write or clear in the
            // same cycle only becomes visible at the following frame.
            if (frame_start) begin
                r_base      <= r_wr_ptr;
                r_fill_snap <= r_fill;
            end else if (clear) begin
                r_fill_snap <= '0;
            end
        end
    end

    // Storage has no reset; stale contents are masked by the fill count.
    always_ff @(posedge clock_65mhz) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= sample_in;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_rd_addr;
    logic [11:0]       w_first_col;
    rd_stage_t         w_s1;

    logic [ADDR_W-1:0] r_rd_addr;
    rd_stage_t         r_s1;
    logic [7:0]        r_signal_out;
    logic              r_signal_valid;
    logic [10:0]       r_hcount_d;
    logic [9:0]        r_vcount_d;

    // Base is the oldest slot once the buffer has wrapped, so column c reads
    // base+c and column WIDTH-1 lands on the newest sample.
    assign w_rd_addr   = r_base + hcount[ADDR_W-1:0];
    // First column holding real data; everything left of it is blank.
    assign w_first_col = WIDTH_EXT - 12'(r_fill_snap);

    always_comb begin
        w_s1          = '0;
        w_s1.hcount   = hcount;
        w_s1.vcount   = vcount;
        w_s1.in_range = ({1'b0, hcount} < WIDTH_EXT);
        w_s1.col_ok   = ({1'b0, hcount} >= w_first_col);
    end

    always_ff @(posedge clock_65mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_addr      <= '0;
            r_s1           <= '0;
            r_signal_out   <= '0;
            r_signal_valid <= 1'b0;
            r_hcount_d     <= '0;
            r_vcount_d     <= '0;
        end else begin
            // Stage 1: address and column qualifiers.
            r_rd_addr <= w_rd_addr;
            r_s1      <= w_s1;

            // Stage 2: RAM read. The write above uses a non-blocking update,
            // so a same-cycle read of the written address sees the old byte.
            r_signal_valid <= r_s1.in_range & r_s1.col_ok;
            if (r_s1.in_range && r_s1.col_ok) begin
                r_signal_out <= r_mem[r_rd_addr];
            end else begin
                r_signal_out <= '0;
            end
            r_hcount_d <= r_s1.hcount;
            r_vcount_d <= r_s1.vcount;
        end
    end

    assign signal_out   = r_signal_out;
    assign signal_valid = r_signal_valid;
    assign hcount_d     = r_hcount_d;
    assign vcount_d     = r_vcount_d;

endmodule

// File: doc/waveform_trace_buffer.md
Name: waveform_trace_buffer

Overview:
- Sample store and read sequencer for the scrolling ECG trace.
- Accepts 8-bit heart-signal samples through a valid/ready handshake into a circular column buffer.
- At every frame start, snapshots the buffer head and fill level. During the raster sweep, it delivers one sample per screen column, oldest at left, newest at right.
- Its outputs drive the waveform renderer's signal_in, plus delayed hcount/vcount for pipeline alignment.

Parameters:
- WIDTH, 1024, number of displayed columns and buffer depth; must be a power of two.
- ADDR_W, 10, log2(WIDTH).

Ports:
- clock_65mhz  in  1  pixel clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- sample_in  in  8  new trace sample
- sample_valid  in  1  sample_in is valid this cycle
- sample_ready  out  1  block accepts a sample this cycle
- freeze  in  1  hold the trace; writes blocked
- clear  in  1  synchronous, one-cycle; empties the buffer
- frame_start  in  1  one-cycle pulse at the start of vertical blank
- hcount  in  11  current raster column
- vcount  in  10  current raster row
- signal_out  out  8  sample for the column of hcount_d
- signal_valid  out  1  signal_out holds real data
- hcount_d  out  11  hcount delayed 2 cycles
- vcount_d  out  10  vcount delayed 2 cycles
- fill_level  out  11  live count of stored samples, 0..WIDTH

Behaviour:
- Reset (reset_n=0, asynchronous)
  - wr_ptr, fill, base, and fill_snap cleared.
  - All outputs 0, including sample_ready.
  - RAM contents are not cleared; they are masked by fill=0.
- Storage: WIDTH x 8 synchronous RAM.
  - Read-first: a same-cycle read of an address being written returns the old data.
- Write path
  - sample_ready = !freeze && !clear, while out of reset.
  - Accept occurs when sample_valid && sample_ready.
  - On accept: mem[wr_ptr] <= sample_in; wr_ptr <= wr_ptr+1 mod WIDTH; fill <= min(fill+1, WIDTH).
  - fill_level = fill.
- clear: wr_ptr <= 0, fill <= 0, fill_snap <= 0. Takes priority over a concurrent write, which is not performed.
- Frame snapshot
  - On frame_start: base <= wr_ptr, fill_snap <= fill.
  - Both use the pre-update values, even if a write accepts in the same cycle.
  - base and fill_snap are constant for the rest of the frame. Later writes do not move the mapping, so no horizontal tearing.
- Read pipeline (2-cycle latency, fixed, every cycle)
  - Stage 1: rd_addr <= (base + hcount[ADDR_W-1:0]) mod WIDTH. Also registers in_range = (hcount < WIDTH) and col_ok = (hcount >= WIDTH - fill_snap).
  - Stage 2: RAM data registered to signal_out.
  - signal_valid <= in_range && col_ok; when not valid, signal_out = 0.
  - hcount_d/vcount_d use the same 2-stage delay.
- Column mapping
  - Column WIDTH-1 shows the newest sample at snapshot time; column WIDTH-1-k shows the sample k older.
  - With fill_snap < WIDTH, columns 0..WIDTH-fill_snap-1 are invalid.
- Wrap-around: wr_ptr and the rd_addr sum wrap modulo WIDTH. fill saturates at WIDTH; after that, the oldest data is overwritten.
- Simultaneous clear and frame_start: snapshot takes the pre-clear values; the cleared state appears at the next frame.
- freeze: the snapshot still updates each frame, but since wr_ptr is static the image is stationary.
- Reset mid-frame: outputs drop to 0 asynchronously. After release, all columns are invalid until samples are written and a frame_start occurs.
- hcount values ≥ WIDTH: signal_valid=0, no RAM side effects.

Test Plan:
- Reset: assert reset_n=0 mid-stream → signal_out=0, signal_valid=0, sample_ready=0, fill_level=0 immediately. After release with freeze=0 → sample_ready=1.
- Partial fill: write 10,20,30; pulse frame_start; sweep hcount 0..1023.
  - Columns 1021/1022/1023 yield 10/20/30 with signal_valid=1, two cycles after the matching hcount.
  - All other columns yield 0 with signal_valid=0.
  - fill_level=3.
- Wrap: write 1030 samples with value n mod 256 (n=0..1029); frame_start.
  - hcount 0 → 6, hcount 1023 → 5 (1029 mod 256); all valid.
  - fill_level=1024.
- Snapshot race: with fill=5, assert frame_start and an accepted write in the same cycle → that frame shows 5 valid columns (1019..1023). The next frame shows 6.
- freeze/clear
  - freeze=1 with sample_valid=1 for 50 cycles → sample_ready=0, fill_level unchanged.
  - clear together with sample_valid=1 → fill_level=0, no write.
  - Next frame → all columns invalid.
- Mid-frame write: after frame_start, write 0xFF during the sweep. Columns in the current frame keep their snapshot mapping (column 1023 value unchanged). The next frame shows 0xFF at column 1023.
